// File: rtl/sram_ctrl.sv
// Two-phase 32-bit access controller for a 16-bit asynchronous SRAM.
// Each load/store is split into a low and a high halfword access of ACCESS_CYCLES clocks each.
module sram_ctrl #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] LAST = 3'(ACCESS_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_wr;
  logic [16:0] r_waddr;
  logic [31:0] r_wdata;

  logic w_req;
  logic w_last;
  logic w_unused;

  assign w_req    = wr_en | rd_en;
  assign w_last   = (r_cnt == LAST);
  assign w_unused = ^{address[31:19], address[1:0]};

  // Freeze the pipeline from the moment a request appears until the DONE cycle.
  assign ready = (r_state == DONE) || ((r_state == IDLE) && !w_req);

  // Bus outputs are loaded on state entry so they are stable for the whole phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state     <= LOW;
            r_cnt       <= '0;
            r_wr        <= wr_en;
            r_waddr     <= address[18:2];
            r_wdata     <= write_data;
            sram_addr   <= {address[18:2], 1'b0};
            sram_dq_out <= wr_en ? write_data[15:0] : 16'h0;
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
            sram_oe_n   <= wr_en;
          end
        end
        LOW: begin
          if (w_last) begin
            r_state   <= HIGH;
            r_cnt     <= '0;
            sram_addr <= {r_waddr, 1'b1};
            if (r_wr) sram_dq_out     <= r_wdata[31:16];
            else      read_data[15:0] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        HIGH: begin
          if (w_last) begin
            r_state     <= DONE;
            r_cnt       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            if (!r_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default-timing instance checked cycle by cycle against a word-level
// memory model, plus an ACCESS_CYCLES=1 instance for back-to-back spacing.
module tb_sram_ctrl;

  localparam int AC0 = 2;
  localparam int AC1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;

  logic [31:0] read_data0, read_data1;
  logic        ready0, ready1;
  logic [17:0] sram_addr0, sram_addr1;
  logic [15:0] dq_out0, dq_out1, dq_in0, dq_in1;
  logic        dq_oe0, dq_oe1, we_n0, we_n1, oe_n0, oe_n1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd = '0;
  logic [15:0] mem0 [0:1023];

  always #5 clk = ~clk;

  sram_ctrl #(.ACCESS_CYCLES(AC0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
    .sram_dq_oe(dq_oe0), .sram_we_n(we_n0), .sram_oe_n(oe_n0));

  sram_ctrl #(.ACCESS_CYCLES(AC1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
    .sram_dq_oe(dq_oe1), .sram_we_n(we_n1), .sram_oe_n(oe_n1));

  // Preloaded SRAM contents: a fixed pattern per halfword address.
  function automatic logic [15:0] pat(input logic [9:0] ha);
    logic [15:0] p;
    p = 16'(ha) * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  // Writable SRAM for dut0; dut1 sees a read-only copy of the preload pattern.
  assign dq_in0 = mem0[sram_addr0[9:0]];
  assign dq_in1 = pat(sram_addr1[9:0]);
  always @(posedge clk) if (!we_n0) mem0[sram_addr0[9:0]] <= dq_out0;

  function automatic logic [31:0] ref_read(input logic [16:0] w);
    logic [9:0] h;
    h = {w[8:0], 1'b0};
    if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
    return {pat(h | 10'd1), pat(h)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_addr"}, 32'(sram_addr0), 32'h0);
    chk({tag, "_we_n"}, 32'(we_n0), 32'h1);
    chk({tag, "_oe_n"}, 32'(oe_n0), 32'h1);
    chk({tag, "_dq_oe"}, 32'(dq_oe0), 32'h0);
  endtask

  task automatic rand_inputs();
    wr_en      = 1'($urandom);
    rd_en      = 1'($urandom);
    address    = $urandom;
    write_data = $urandom;
  endtask

  task automatic zero_inputs();
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
  endtask

  // One full access on dut0; inputs are scrambled after the request cycle to show they are ignored.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input int stop_at);
    int n;
    logic [16:0] w;
    logic is_wr, active;
    logic [17:0] ea;
    logic [15:0] half;
    n = 2 * AC0 + 1;
    w = a[18:2];
    is_wr = wr;
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    @(negedge clk);
    chk("req_ready", 32'(ready0), 32'h0);
    chk_idle_bus("req");
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c < n) rand_inputs(); else zero_inputs();
      @(negedge clk);
      active = (c <= 2 * AC0);
      ea   = (c <= AC0) ? {w, 1'b0} : {w, 1'b1};
      half = (c <= AC0) ? d[15:0] : d[31:16];
      chk("ready", 32'(ready0), 32'(c == n));
      chk("addr", 32'(sram_addr0), active ? 32'(ea) : 32'h0);
      chk("we_n", 32'(we_n0), 32'(!(active && is_wr)));
      chk("oe_n", 32'(oe_n0), 32'(!(active && !is_wr)));
      chk("dq_oe", 32'(dq_oe0), 32'(active && is_wr));
      if (active && is_wr) chk("dq_out", 32'(dq_out0), 32'(half));
      if (c == stop_at) return;
      if (c == n) begin
        if (!is_wr) exp_rd = ref_read(w);
        chk("read_data", read_data0, exp_rd);
      end
    end
    if (is_wr) ref_mem[int'(w)] = d;
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [16:0] w;
    logic [31:0] exp1;
    int op;
    for (int i = 0; i < 1024; i++) mem0[i] = pat(10'(i));

    // Reset held for 3 clocks with random inputs.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rand_inputs();
      @(negedge clk);
      chk("rst_read_data", read_data0, 32'h0);
      chk("rst_dq_out", 32'(dq_out0), 32'h0);
      chk_idle_bus("rst");
      chk("rst_ready", 32'(ready0), 32'(!(wr_en || rd_en)));
      chk("rst_ready1", 32'(ready1), 32'(!(wr_en || rd_en)));
    end
    @(posedge clk); #1;
    zero_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(ready0), 32'h1);
    chk("idle_ready1", 32'(ready1), 32'h1);

    access(1'b1, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF, 0);
    access(1'b0, 1'b1, 32'h0000_0404, 32'h0, 0);
    chk("rd_404", read_data0, 32'hDEAD_BEEF);
    access(1'b1, 1'b1, 32'h0000_0808, 32'h1234_5678, 0);
    chk("both_keeps_rd", read_data0, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h0000_0808, 32'h0, 0);

    for (int t = 0; t < 24; t++) begin
      w  = 17'($urandom_range(0, 31));
      a  = ($urandom & 32'hFFF8_0003) | (32'(w) << 2);
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, a, $urandom, 0);
    end

    // Reset during the HIGH phase of a read takes effect without a clock edge.
    access(1'b0, 1'b1, 32'h0000_0040, 32'h0, AC0 + 1);
    #1;
    rst = 1'b0;
    zero_inputs();
    #1;
    exp_rd = '0;
    chk("abort_read_data", read_data0, 32'h0);
    chk_idle_bus("abort");
    chk("abort_ready", 32'(ready0), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    chk("abort_hold", read_data0, 32'h0);
    access(1'b0, 1'b1, 32'h0000_0044, 32'h0, 0);

    // ACCESS_CYCLES=1 with a held read: one-clock ready pulse every 4 clocks.
    repeat (4) @(posedge clk);
    #1;
    w = 17'h0A5;
    rd_en = 1'b1;
    address = 32'(w) << 2;
    exp1 = {pat({w[8:0], 1'b1}), pat({w[8:0], 1'b0})};
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("spc_ready", 32'(ready1), 32'(k % 4 == 3));
      chk("spc_addr", 32'(sram_addr1),
          (k % 4 == 1) ? 32'({w, 1'b0}) : (k % 4 == 2) ? 32'({w, 1'b1}) : 32'h0);
      if (k % 4 == 3) chk("spc_read_data", read_data1, exp1);
    end
    @(posedge clk); #1;
    zero_inputs();
    repeat (8) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, meaning clocks per 16-bit SRAM half-access (legal range 1..7).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port wr_en, input, 1 bit: MEM-stage store request.
REQ-005 SHALL have port rd_en, input, 1 bit: MEM-stage load request.
REQ-006 SHALL have port address, input, 32 bits: byte address from the ALU result.
REQ-007 SHALL have port write_data, input, 32 bits: store data.
REQ-008 SHALL have port read_data, output, 32 bits: registered load result.
REQ-009 SHALL have port ready, output, 1 bit: access complete; pipeline freeze = ~ready.
REQ-010 SHALL have port sram_addr, output, 18 bits: SRAM halfword address.
REQ-011 SHALL have port sram_dq_out, output, 16 bits: data driven to SRAM.
REQ-012 SHALL have port sram_dq_in, input, 16 bits: data returned from SRAM.
REQ-013 SHALL have port sram_dq_oe, output, 1 bit: 1 = drive sram_dq_out onto the bus.
REQ-014 SHALL have port sram_we_n, output, 1 bit: SRAM write strobe, active-low.
REQ-015 SHALL have port sram_oe_n, output, 1 bit: SRAM output enable, active-low.

Function
REQ-016 SHALL implement states IDLE, LOW, HIGH, DONE, held in a registered state plus a 3-bit phase counter.
REQ-017 SHALL leave IDLE for LOW when (wr_en | rd_en) = 1 in IDLE; otherwise SHALL remain in IDLE.
REQ-018 SHALL latch op (write if wr_en = 1, else read), address[18:2] and write_data on the IDLE->LOW transition; write SHALL win when wr_en and rd_en are both 1.
REQ-019 SHALL remain in LOW for exactly ACCESS_CYCLES clocks, then in HIGH for exactly ACCESS_CYCLES clocks, then in DONE for exactly 1 clock, then return to IDLE.
REQ-020 SHALL drive sram_addr = {latched word address, 1'b0} in LOW and {latched word address, 1'b1} in HIGH; SHALL drive 0 in IDLE and DONE.
REQ-021 For a write, SHALL hold sram_we_n = 0, sram_dq_oe = 1 and sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-022 For a read, SHALL hold sram_oe_n = 0 and sram_dq_oe = 0 in LOW/HIGH; SHALL capture sram_dq_in into read_data[15:0] on the last LOW clock and into read_data[31:16] on the last HIGH clock.
REQ-023 SHALL leave read_data unchanged by writes; it SHALL hold the last completed read until the next read completes.
REQ-024 SHALL generate ready combinationally: 1 in DONE; 1 in IDLE when wr_en = rd_en = 0; 0 otherwise, including IDLE with a request present.
REQ-025 For a request first seen at cycle 0, ready SHALL be 0 for cycles 0..2*ACCESS_CYCLES and 1 at cycle 2*ACCESS_CYCLES+1 (cycle 5 at default).
REQ-026 SHALL ignore changes or drops of wr_en/rd_en/address/write_data after the IDLE->LOW transition; the latched access SHALL complete.
REQ-027 A request still asserted in DONE SHALL NOT start a new access; a new access SHALL start only from IDLE on the following cycle (back-to-back spacing 2*ACCESS_CYCLES+2 clocks).
REQ-028 SHALL hold sram_we_n = sram_oe_n = 1 and sram_dq_oe = 0 in IDLE and DONE.

Reset
REQ-029 On rst = 0, SHALL go immediately to IDLE with counter = 0, read_data = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1, sram_oe_n = 1, and ready per REQ-024.
REQ-030 Reset asserted mid-access SHALL abort the access with no further read_data update; after release, operation SHALL start from IDLE.

Verification
REQ-031 The bench SHALL cover reset: rst = 0 for 3 clocks with random inputs -> all outputs at REQ-029 values; ready = 1 with no request.
REQ-032 The bench SHALL cover a write: wr_en = 1, address = 0x0000_0404, write_data = 0xDEAD_BEEF -> sram_addr = 0x202 with dq 0xBEEF for 2 clocks, then 0x203 with dq 0xDEAD for 2 clocks; ready = 1 at cycle 5.
REQ-033 The bench SHALL cover a read: rd_en = 1 at the same address, with the SRAM model returning 0xBEEF/0xDEAD -> read_data = 0xDEAD_BEEF at the DONE cycle; ready low for cycles 0..4.
REQ-034 The bench SHALL cover simultaneous requests: wr_en = rd_en = 1 -> write performed, read_data unchanged.
REQ-035 The bench SHALL cover reset mid-access: rst = 0 during HIGH of a read -> IDLE, read_data = 0 and sram_oe_n = 1 immediately, without waiting for a clock edge.
REQ-036 The bench SHALL cover the parameter and spacing: ACCESS_CYCLES = 1 with rd_en held high -> ready pulses every 4 clocks (1 clock wide), with no overlapping accesses.
